// File: rtl/squash_io_pkg.sv
// Shared state encoding, default timing constants and counter sizing for the squash I/O sequencer.
// No datapath, no latency, no backpressure.
package squash_io_pkg;

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        HOLD_RESET = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam int SQ_READY_CYCLES    = 16;
    localparam int SQ_RESET_HOLD      = 8;
    localparam int SQ_DEBOUNCE_CYCLES = 4;

    // Counter width for a terminal count, never narrower than one bit.
    function automatic int cnt_w(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/squash_debounce.sv
// One button: 2-flop synchronizer, stability counter and registered active-high output.
// Latency 2+DEBOUNCE_CYCLES cycles pad-to-output; no backpressure, clr forces output and counter to 0.
module squash_debounce
    import squash_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SQ_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic btn_n_raw,
    output logic btn
);

    localparam int              CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          btn_q, btn_d;
    logic          pressed;

    always_comb begin
        sync_d  = {sync_q[0], btn_n_raw};
        pressed = ~sync_q[1];
        cnt_d   = '0;
        btn_d   = btn_q;
        if (clr) begin
            btn_d = 1'b0;
        end else if (pressed != btn_q) begin
            // Toggle only once the new level has held for the full window.
            if (cnt_q == CNT_LAST) begin
                btn_d = pressed;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            btn_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            btn_q  <= btn_d;
        end
    end

    assign btn = btn_q;

endmodule

// File: rtl/squash_io_sequencer.sv
// Power-up/reset sequencer for the game core plus debounced pad buttons and a new-game pulse.
// design_reset decoded straight from state; no backpressure, all inputs treated as asynchronous.
module squash_io_sequencer
    import squash_io_pkg::*;
#(
    parameter int READY_CYCLES    = SQ_READY_CYCLES,
    parameter int RESET_HOLD      = SQ_RESET_HOLD,
    parameter int DEBOUNCE_CYCLES = SQ_DEBOUNCE_CYCLES
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       gpio_ready,
    input  logic       ext_reset_n,
    input  logic [3:0] btn_n,
    output logic       design_reset,
    output logic [3:0] btn,
    output logic       new_game_pulse,
    output logic [1:0] state_dbg,
    output logic       debug_gpio_ready
);

    localparam int            RW       = cnt_w(READY_CYCLES);
    localparam int            HW       = cnt_w(RESET_HOLD);
    localparam logic [RW-1:0] RDY_LAST = RW'(READY_CYCLES - 1);
    localparam logic [HW-1:0] HLD_LAST = HW'(RESET_HOLD - 1);

    logic [1:0]    gpio_sync_q, gpio_sync_d;
    logic [1:0]    ext_sync_q, ext_sync_d;
    state_t        state_q, state_d;
    logic [RW-1:0] rdy_cnt_q, rdy_cnt_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          ng_prev_q, ng_prev_d;
    logic          pulse_q, pulse_d;
    logic          gpio_ok, ext_ok;
    logic          btn_clr;
    logic [3:0]    btn_db;

    always_comb begin
        gpio_sync_d = {gpio_sync_q[0], gpio_ready};
        ext_sync_d  = {ext_sync_q[0], ext_reset_n};
        gpio_ok     = gpio_sync_q[1];
        ext_ok      = ext_sync_q[1];
        state_d     = state_q;
        rdy_cnt_d   = '0;
        hold_cnt_d  = '0;
        case (state_q)
            WAIT_READY: begin
                if (gpio_ok) begin
                    if (rdy_cnt_q == RDY_LAST) begin
                        state_d = HOLD_RESET;
                    end else begin
                        rdy_cnt_d = rdy_cnt_q + 1'b1;
                    end
                end
            end
            HOLD_RESET: begin
                // Losing gpio_ready beats everything; a low pad reset keeps the hold count pinned at 0.
                if (!gpio_ok) begin
                    state_d = WAIT_READY;
                end else if (ext_ok) begin
                    if (hold_cnt_q == HLD_LAST) begin
                        state_d = RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (!gpio_ok) begin
                    state_d = WAIT_READY;
                end else if (!ext_ok) begin
                    state_d = HOLD_RESET;
                end
            end
            default: state_d = WAIT_READY;
        endcase
    end

    // Clearing from the next state keeps btn at 0 in exactly the cycles the state is not RUN.
    always_comb begin
        btn_clr   = (state_d != RUN);
        ng_prev_d = btn_clr ? 1'b0 : btn_db[1];
        pulse_d   = ~btn_clr & btn_db[1] & ~ng_prev_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            gpio_sync_q <= 2'b00;
            ext_sync_q  <= 2'b11;
            state_q     <= WAIT_READY;
            rdy_cnt_q   <= '0;
            hold_cnt_q  <= '0;
            ng_prev_q   <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            gpio_sync_q <= gpio_sync_d;
            ext_sync_q  <= ext_sync_d;
            state_q     <= state_d;
            rdy_cnt_q   <= rdy_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            ng_prev_q   <= ng_prev_d;
            pulse_q     <= pulse_d;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_btn
        squash_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .clr      (btn_clr),
            .btn_n_raw(btn_n[i]),
            .btn      (btn_db[i])
        );
    end

    assign design_reset     = (state_q != RUN);
    assign btn              = btn_db;
    assign new_game_pulse   = pulse_q;
    assign state_dbg        = state_q;
    assign debug_gpio_ready = gpio_sync_q[1];

endmodule

// File: tb/tb_squash_io_sequencer.sv
// Directed bench for squash_io_sequencer at default parameters.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_squash_io_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       gpio_ready;
    logic       ext_reset_n;
    logic [3:0] btn_n;
    logic       design_reset;
    logic [3:0] btn;
    logic       new_game_pulse;
    logic [1:0] state_dbg;
    logic       debug_gpio_ready;

    int total = 0;
    int bad   = 0;

    squash_io_sequencer dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .gpio_ready      (gpio_ready),
        .ext_reset_n     (ext_reset_n),
        .btn_n           (btn_n),
        .design_reset    (design_reset),
        .btn             (btn),
        .new_game_pulse  (new_game_pulse),
        .state_dbg       (state_dbg),
        .debug_gpio_ready(debug_gpio_ready)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_run();
        rst = 1'b1; gpio_ready = 1'b0; ext_reset_n = 1'b1; btn_n = 4'hF;
        tick(2);
        rst = 1'b0; gpio_ready = 1'b1;
        tick(26);
    endtask

    task automatic test_reset();
        rst = 1'b1; gpio_ready = 1'b0; ext_reset_n = 1'b1; btn_n = 4'hF;
        tick(3);
        total++; if (design_reset !== 1'b1) begin bad++; $display("FAIL reset_design_reset got=%b want=1", design_reset); end
        total++; if (btn !== 4'h0) begin bad++; $display("FAIL reset_btn got=%h want=0", btn); end
        total++; if (new_game_pulse !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b want=0", new_game_pulse); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state_dbg); end
        total++; if (debug_gpio_ready !== 1'b0) begin bad++; $display("FAIL reset_gpio_dbg got=%b want=0", debug_gpio_ready); end
        rst = 1'b0;
        tick(2);
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL idle_state got=%0d want=0", state_dbg); end
    endtask

    task automatic test_power_up();
        logic [1:0] exp_st;
        logic       exp_dr;
        gpio_ready = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            exp_st = (k >= 26) ? 2'd2 : (k >= 18) ? 2'd1 : 2'd0;
            exp_dr = (k < 26);
            total++; if (state_dbg !== exp_st) begin bad++; $display("FAIL pwr_state k=%0d got=%0d want=%0d", k, state_dbg, exp_st); end
            total++; if (design_reset !== exp_dr) begin bad++; $display("FAIL pwr_design_reset k=%0d got=%b want=%b", k, design_reset, exp_dr); end
            if (k <= 2) begin
                total++; if (debug_gpio_ready !== (k == 2)) begin bad++; $display("FAIL pwr_gpio_dbg k=%0d got=%b want=%b", k, debug_gpio_ready, (k == 2)); end
            end
        end
    endtask

    task automatic test_ready_glitch();
        rst = 1'b1; gpio_ready = 1'b0; ext_reset_n = 1'b1; btn_n = 4'hF;
        tick(2);
        rst = 1'b0;
        gpio_ready = 1'b1; tick(10);
        gpio_ready = 1'b0; tick(1);
        gpio_ready = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            if (k == 15) begin
                total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL glitch_restart_state got=%0d want=0", state_dbg); end
            end
            if (k == 18) begin
                total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL glitch_hold_state got=%0d want=1", state_dbg); end
            end
            if (k == 25) begin
                total++; if (design_reset !== 1'b1) begin bad++; $display("FAIL glitch_dr_25 got=%b want=1", design_reset); end
            end
            if (k == 26) begin
                total++; if (design_reset !== 1'b0) begin bad++; $display("FAIL glitch_dr_26 got=%b want=0", design_reset); end
            end
        end
    endtask

    task automatic test_ext_reset();
        ext_reset_n = 1'b0;
        tick(2);
        total++; if (design_reset !== 1'b0) begin bad++; $display("FAIL ext_dr_early got=%b want=0", design_reset); end
        tick(1);
        total++; if (design_reset !== 1'b1) begin bad++; $display("FAIL ext_dr_3 got=%b want=1", design_reset); end
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL ext_state got=%0d want=1", state_dbg); end
        tick(17);
        total++; if (state_dbg !== 2'd1) begin bad++; $display("FAIL ext_state_held got=%0d want=1", state_dbg); end
        ext_reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick(1);
            total++; if (design_reset !== (k < 10)) begin bad++; $display("FAIL ext_release k=%0d got=%b want=%b", k, design_reset, (k < 10)); end
        end
    endtask

    task automatic test_button_glitch();
        int seen_btn = 0;
        int seen_pulse = 0;
        btn_n[1] = 1'b0;
        tick(3);
        btn_n[1] = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (btn !== 4'h0) seen_btn++;
            if (new_game_pulse !== 1'b0) seen_pulse++;
        end
        total++; if (seen_btn != 0) begin bad++; $display("FAIL glitch_btn cycles_changed=%0d want=0", seen_btn); end
        total++; if (seen_pulse != 0) begin bad++; $display("FAIL glitch_pulse cycles_pulsed=%0d want=0", seen_pulse); end
    endtask

    task automatic test_button_press();
        logic exp_b;
        logic exp_p;
        btn_n[1] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            tick(1);
            if (k == 10) btn_n[1] = 1'b1;
            exp_b = (k >= 6) && (k < 16);
            exp_p = (k == 7);
            total++; if (btn !== {2'b00, exp_b, 1'b0}) begin bad++; $display("FAIL press_btn k=%0d got=%h want=%h", k, btn, {2'b00, exp_b, 1'b0}); end
            total++; if (new_game_pulse !== exp_p) begin bad++; $display("FAIL press_pulse k=%0d got=%b want=%b", k, new_game_pulse, exp_p); end
        end
    endtask

    task automatic test_gpio_drop();
        go_run();
        btn_n[3] = 1'b0;
        tick(8);
        total++; if (btn !== 4'h8) begin bad++; $display("FAIL drop_btn_before got=%h want=8", btn); end
        gpio_ready = 1'b0;
        tick(2);
        total++; if (design_reset !== 1'b0) begin bad++; $display("FAIL drop_dr_early got=%b want=0", design_reset); end
        tick(1);
        total++; if (design_reset !== 1'b1) begin bad++; $display("FAIL drop_dr got=%b want=1", design_reset); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL drop_state got=%0d want=0", state_dbg); end
        total++; if (btn !== 4'h0) begin bad++; $display("FAIL drop_btn got=%h want=0", btn); end
        tick(6);
        total++; if (btn !== 4'h0) begin bad++; $display("FAIL drop_btn_held got=%h want=0", btn); end
        btn_n = 4'hF; gpio_ready = 1'b1;
        tick(25);
        total++; if (design_reset !== 1'b1) begin bad++; $display("FAIL drop_rerun_25 got=%b want=1", design_reset); end
        tick(1);
        total++; if (design_reset !== 1'b0) begin bad++; $display("FAIL drop_rerun_26 got=%b want=0", design_reset); end
    endtask

    task automatic test_mid_reset();
        btn_n[0] = 1'b0;
        tick(8);
        total++; if (btn !== 4'h1) begin bad++; $display("FAIL midrst_btn_before got=%h want=1", btn); end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        total++; if (design_reset !== 1'b1) begin bad++; $display("FAIL midrst_dr got=%b want=1", design_reset); end
        total++; if (btn !== 4'h0) begin bad++; $display("FAIL midrst_btn got=%h want=0", btn); end
        total++; if (new_game_pulse !== 1'b0) begin bad++; $display("FAIL midrst_pulse got=%b want=0", new_game_pulse); end
        total++; if (state_dbg !== 2'd0) begin bad++; $display("FAIL midrst_state got=%0d want=0", state_dbg); end
        total++; if (debug_gpio_ready !== 1'b0) begin bad++; $display("FAIL midrst_gpio_dbg got=%b want=0", debug_gpio_ready); end
    endtask

    initial begin
        rst = 1'b1; gpio_ready = 1'b0; ext_reset_n = 1'b1; btn_n = 4'hF;
        test_reset();
        test_power_up();
        test_ready_glitch();
        test_ext_reset();
        test_button_glitch();
        test_button_press();
        test_gpio_drop();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/squash_io_sequencer.md
SQUASH_IO_SEQUENCER -- requirements
Module: squash_io_sequencer

Interface
REQ-001 Parameter READY_CYCLES, default 16: consecutive synchronized-high gpio_ready cycles required before leaving WAIT_READY.
REQ-002 Parameter RESET_HOLD, default 8: minimum design_reset hold cycles in HOLD_RESET.
REQ-003 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required before a button output changes.
REQ-004 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-006 gpio_ready  in  1  firmware "GPIO configured" flag from the logic analyser; asynchronous.
REQ-007 ext_reset_n  in  1  pad reset request, active-low; asynchronous.
REQ-008 btn_n  in  4  pad buttons, active-low, asynchronous: [0] pause, [1] new_game, [2] down_key, [3] up_key.
REQ-009 design_reset  out  1  reset to the game core, active-high.
REQ-010 btn  out  4  debounced buttons, active-high, same bit order as btn_n.
REQ-011 new_game_pulse  out  1  one-cycle pulse on the debounced rising edge of btn[1].
REQ-012 state_dbg  out  2  current FSM state encoding.
REQ-013 debug_gpio_ready  out  1  synchronized gpio_ready.

Function
REQ-014 gpio_ready, ext_reset_n and each btn_n bit SHALL pass through a 2-flop synchronizer before any use; no other logic touches the raw inputs.
REQ-015 FSM states: WAIT_READY=0, HOLD_RESET=1, RUN=2; encoding 3 is unreachable and SHALL recover to WAIT_READY on the next cycle.
REQ-016 WAIT_READY: ready counter increments while synced gpio_ready=1 and clears when it is 0; on a cycle with synced gpio_ready=1 and counter=READY_CYCLES-1, go to HOLD_RESET with hold counter=0.
REQ-017 HOLD_RESET: hold counter increments each cycle; it is held at 0 while synced ext_reset_n=0; on counter=RESET_HOLD-1 with synced ext_reset_n=1, go to RUN.
REQ-018 RUN: synced ext_reset_n=0 -> HOLD_RESET with hold counter=0.
REQ-019 In HOLD_RESET or RUN, synced gpio_ready=0 -> WAIT_READY with ready counter=0; this takes priority over every other transition.
REQ-020 design_reset SHALL equal (state != RUN) and be decoded directly from the state register (glitch-free, no added latency).
REQ-021 With ext_reset_n high, RUN is entered exactly 2+READY_CYCLES+RESET_HOLD rising edges after gpio_ready rises (26 at defaults).
REQ-022 Debounce per bit: a counter increments while the synced, inverted input differs from btn[i] and clears when they match; btn[i] toggles and the counter clears when the counter reaches DEBOUNCE_CYCLES-1 while they still differ.
REQ-023 Debounce latency from a pad edge to the btn change SHALL be exactly 2+DEBOUNCE_CYCLES cycles.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL NOT change btn.
REQ-025 While state != RUN, btn=0, new_game_pulse=0 and all debounce counters are held at 0.
REQ-026 new_game_pulse=1 for exactly one cycle on the cycle after btn[1] goes 0->1; holding the button produces no further pulses.
REQ-027 Counters SHALL be sized $clog2 of their terminal count (minimum 1 bit) and SHALL never wrap.

Reset
REQ-028 While wb_rst_i=1 at a clock edge: state=WAIT_READY, design_reset=1, all counters=0, btn=0, new_game_pulse=0, synchronizer flops=inactive (gpio_ready 0, ext_reset_n 1, btn_n 1), state_dbg=0.
REQ-029 Reset asserted mid-operation, including in RUN, SHALL take effect on the next edge and override every other transition.

Structure
REQ-030 Shared package squash_io_pkg SHALL hold the state enum and the default values of READY_CYCLES, RESET_HOLD and DEBOUNCE_CYCLES.
REQ-031 Sub-module squash_debounce (2-flop sync, counter, output flop, clear input) SHALL be instantiated once per button bit.
REQ-032 Target size: 150-300 lines of RTL total.

Verification
REQ-033 Reset, then gpio_ready=1 and ext_reset_n=1 held -> design_reset falls exactly 26 cycles after gpio_ready rises; state_dbg 0->1->2.
REQ-034 gpio_ready high for 10 cycles, low for 1, then high -> ready counter restarts; RUN entered 26 cycles after the final rise.
REQ-035 In RUN, ext_reset_n low for 20 cycles -> design_reset=1 within 3 cycles; RUN re-entered 2+8 cycles after ext_reset_n rises.
REQ-036 In RUN, btn_n[1] low for 3 cycles -> no change on btn or new_game_pulse; low for 10 cycles -> btn[1] rises 6 cycles after the pad edge, followed by one new_game_pulse.
REQ-037 In RUN with btn[3]=1, drop gpio_ready -> WAIT_READY, design_reset=1, btn=0 within 3 cycles.
REQ-038 Assert wb_rst_i for 1 cycle in RUN with btn[0]=1 -> next cycle all outputs at reset values.
